// File: rtl/vga_frame_capture_if.sv
// Capture-buffer write port: one strobe per written mono pixel.
// Ports: pix_we strobe, pix_addr row*cols+col, pix_data mono pixel.
interface vga_frame_capture_if #(
    parameter int AW = 15
);
    logic          pix_we;
    logic [AW-1:0] pix_addr;
    logic          pix_data;

    modport master (
        output pix_we,
        output pix_addr,
        output pix_data
    );

    modport slave (
        input pix_we,
        input pix_addr,
        input pix_data
    );
endinterface

// File: rtl/vga_frame_capture.sv
// Recovers the active picture from a VGA sync stream, downsamples it
// by VGA_DIV and writes one mono pixel per grid point to a buffer.
// Ports: clk_vga/reset_n; hsync/vsync/red/green/blue VGA input;
// cap_en arms capture; wr write port; frame_done/frame_err pulses;
// busy high outside IDLE.
module vga_frame_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_BACK   = 33,
    parameter int VGA_DIV  = 4,
    parameter int AW       = 15
) (
    input  logic                clk_vga,
    input  logic                reset_n,
    input  logic                hsync,
    input  logic                vsync,
    input  logic [1:0]          red,
    input  logic [2:0]          green,
    input  logic [2:0]          blue,
    input  logic                cap_en,
    vga_frame_capture_if.master wr,
    output logic                frame_done,
    output logic                frame_err,
    output logic                busy
);
    localparam int LG   = $clog2(VGA_DIV);
    localparam int PW   = $clog2(H_ACTIVE);
    localparam int LW   = $clog2(V_ACTIVE + 1);
    localparam int CMAX = (V_BACK > H_BACK) ? V_BACK : H_BACK;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [AW-1:0] COLS = AW'(H_ACTIVE / VGA_DIV);

    typedef enum logic [2:0] {
        IDLE, WAIT_VS, V_BACK_S, H_WAIT, H_BACK_S, ACTIVE, DONE
    } state_t;

    state_t        r_state, w_state_n;
    logic [PW-1:0] r_px, w_px_n;
    logic [LW-1:0] r_line, w_line_n;
    logic [CW-1:0] r_cnt, w_cnt_n;

    // {hsync, vsync, rgb}; syncs reset high so no false edge after reset
    logic [9:0] r_s1, r_s2;
    logic       r_hs_d, r_vs_d;

    logic          r_we, r_data, r_done, r_err;
    logic [AW-1:0] r_addr;
    logic          w_we, w_done, w_err;
    logic          w_hs, w_vs, w_pix, w_grid;
    logic          w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
    logic [AW-1:0] w_addr;

    assign w_hs      = r_s2[9];
    assign w_vs      = r_s2[8];
    assign w_pix     = |r_s2[7:0];
    assign w_hs_rise = w_hs & ~r_hs_d;
    assign w_hs_fall = ~w_hs & r_hs_d;
    assign w_vs_rise = w_vs & ~r_vs_d;
    assign w_vs_fall = ~w_vs & r_vs_d;

    assign w_grid = (r_px[LG-1:0] == '0) && (r_line[LG-1:0] == '0);
    assign w_addr = AW'(r_line >> LG) * COLS + AW'(r_px >> LG);

    always_comb begin
        w_state_n = r_state;
        w_px_n    = r_px;
        w_line_n  = r_line;
        w_cnt_n   = r_cnt;
        w_we      = 1'b0;
        w_done    = 1'b0;
        w_err     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cap_en) w_state_n = WAIT_VS;
            end
            WAIT_VS: begin
                if (w_vs_rise) begin
                    w_state_n = V_BACK_S;
                    w_line_n  = '0;
                    w_cnt_n   = '0;
                end
            end
            V_BACK_S: begin
                if (w_vs_fall) begin
                    w_err     = 1'b1;
                    w_state_n = WAIT_VS;
                end else if (w_hs_rise) begin
                    // the V_BACK-th edge starts visible line 0;
                    // the edge cycle itself is back-porch cycle 0
                    if (r_cnt == CW'(V_BACK - 1)) begin
                        w_state_n = H_BACK_S;
                        w_cnt_n   = CW'(1);
                        w_line_n  = '0;
                    end else begin
                        w_cnt_n = r_cnt + CW'(1);
                    end
                end
            end
            H_WAIT: begin
                if (w_vs_fall) begin
                    w_err     = 1'b1;
                    w_state_n = WAIT_VS;
                end else if (w_hs_rise) begin
                    w_state_n = H_BACK_S;
                    w_cnt_n   = CW'(1);
                end
            end
            H_BACK_S: begin
                if (w_vs_fall) begin
                    w_err     = 1'b1;
                    w_state_n = WAIT_VS;
                end else if (r_cnt == CW'(H_BACK - 1)) begin
                    w_state_n = ACTIVE;
                    w_px_n    = '0;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            ACTIVE: begin
                if (w_vs_fall ||
                    (w_hs_fall && r_px != PW'(H_ACTIVE - 1))) begin
                    w_err     = 1'b1;
                    w_state_n = WAIT_VS;
                end else begin
                    w_we = w_grid;
                    if (r_px == PW'(H_ACTIVE - 1)) begin
                        w_px_n    = '0;
                        w_line_n  = r_line + LW'(1);
                        w_state_n = (r_line == LW'(V_ACTIVE - 1))
                                    ? DONE : H_WAIT;
                    end else begin
                        w_px_n = r_px + PW'(1);
                    end
                end
            end
            DONE: begin
                w_done    = 1'b1;
                w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_px    <= '0;
            r_line  <= '0;
            r_cnt   <= '0;
            r_s1    <= {2'b11, 8'h00};
            r_s2    <= {2'b11, 8'h00};
            r_hs_d  <= 1'b1;
            r_vs_d  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_px    <= w_px_n;
            r_line  <= w_line_n;
            r_cnt   <= w_cnt_n;
            r_s1    <= {hsync, vsync, red, green, blue};
            r_s2    <= r_s1;
            r_hs_d  <= w_hs;
            r_vs_d  <= w_vs;
            r_we    <= w_we;
            if (w_we) begin
                r_addr <= w_addr;
                r_data <= w_pix;
            end
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    assign wr.pix_we   = r_we;
    assign wr.pix_addr = r_addr;
    assign wr.pix_data = r_data;
    assign frame_done  = r_done;
    assign frame_err   = r_err;
    assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture: a table of frames driven through a
// small VGA timing, checked against a grid-sampling picture model.
module tb_vga_frame_capture;
    localparam int HA = 16, VA = 12, HB = 3, VB = 2, DIV = 4, AW = 4;
    localparam int HS = 2, HF = 3, VSL = 2, VFL = 2;
    localparam int LINE = HS + HB + HA + HF;
    localparam int Y0 = VSL + VB - 1;
    localparam int NL = Y0 + VA + VFL;
    localparam int COLS = HA / DIV;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       hsync = 1'b1, vsync = 1'b1, cap_en = 1'b0;
    logic [1:0] red = '0;
    logic [2:0] green = '0, blue = '0;
    logic       frame_done, frame_err, busy;

    vga_frame_capture_if #(.AW(AW)) wr_if ();

    vga_frame_capture #(
        .H_ACTIVE(HA), .H_BACK(HB), .V_ACTIVE(VA),
        .V_BACK(VB), .VGA_DIV(DIV), .AW(AW)
    ) dut (
        .clk_vga(clk), .reset_n(reset_n),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .cap_en(cap_en), .wr(wr_if.master),
        .frame_done(frame_done), .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // kind: 0 clean, 1 vsync abort, 2 hsync abort, 3 reset pulse
    typedef struct {
        int arm; int kind; int fill;
        int ew; int ed; int ee; int eb; int cap;
    } vec_t;

    vec_t tbl [13];
    int   errors = 0, checks = 0;
    int   got_a [$];
    bit   got_d [$];
    int   exp_a [$];
    bit   exp_d [$];
    int   done_n = 0, err_n = 0, cyc = 0;
    int   last_we_cyc = 0, done_cyc = 0;
    logic [7:0] img [VA][HA];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (wr_if.pix_we) begin
            got_a.push_back(int'(wr_if.pix_addr));
            got_d.push_back(wr_if.pix_data);
            last_we_cyc = cyc;
        end
        if (frame_done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (frame_err) err_n++;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic abort_pt(input int kind, output int ay, output int ax);
        ay = VA;
        ax = 0;
        if (kind == 1) begin ay = 4; ax = 8; end
        if (kind == 2) begin ay = 0; ax = 3; end
        if (kind == 3) begin ay = 6; ax = 5; end
    endtask

    task automatic make_image(input int fill);
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++) begin
                if (fill == 2)
                    img[y][x] = 8'h04;
                else if (fill == 1)
                    img[y][x] = 8'h00;
                else
                    img[y][x] = ($urandom_range(0, 1) == 1)
                                ? 8'h00 : 8'($urandom);
            end
        if (fill == 1) begin
            img[8][4]   = 8'h40;
            img[11][15] = 8'h40;
        end
    endtask

    // Model: every grid point seen before the abort point is written
    // in raster order, with data = any colour bit set.
    task automatic model_frame(input vec_t v);
        int ay, ax;
        abort_pt(v.kind, ay, ax);
        exp_a.delete();
        exp_d.delete();
        if (v.cap != 0)
            for (int y = 0; y < VA; y += DIV)
                for (int x = 0; x < HA; x += DIV)
                    if (y < ay || (y == ay && x < ax)) begin
                        exp_a.push_back((y / DIV) * COLS + x / DIV);
                        exp_d.push_back(img[y][x] != 8'h00);
                    end
    endtask

    task automatic drive_frame(input vec_t v);
        int ay, ax, y, x;
        bit vis, hit, vs_low;
        logic [7:0] col;
        abort_pt(v.kind, ay, ax);
        vs_low = 1'b0;
        for (int ln = 0; ln < NL; ln++)
            for (int c = 0; c < LINE; c++) begin
                @(negedge clk);
                y   = ln - Y0;
                x   = c - (HS + HB);
                vis = (y >= 0 && y < VA && x >= 0 && x < HA);
                hit = vis && v.kind != 0 && y == ay && x == ax;
                if (hit && v.kind == 1) vs_low = 1'b1;
                hsync  = (c >= HS) && !(hit && v.kind == 2);
                vsync  = (ln >= VSL) && !vs_low;
                col    = vis ? img[y][x] : 8'($urandom);
                {red, green, blue} = col;
                cap_en = (v.arm != 0) && ln == 0 && (c == 5 || c == 6);
                if (hit && v.kind == 3) begin
                    reset_n = 1'b0;
                    #1;
                    check("rst_we", int'(wr_if.pix_we), 0);
                    check("rst_addr", int'(wr_if.pix_addr), 0);
                    check("rst_data", int'(wr_if.pix_data), 0);
                    check("rst_done", int'(frame_done), 0);
                    check("rst_err", int'(frame_err), 0);
                    check("rst_busy", int'(busy), 0);
                end else begin
                    reset_n = 1'b1;
                end
            end
    endtask

    initial begin
        int ga0, dn0, er0, nw;
        tbl[0]  = '{1, 0, 1, 12, 1, 0, 0, 1};
        tbl[1]  = '{1, 0, 2, 12, 1, 0, 0, 1};
        tbl[2]  = '{1, 1, 0,  6, 0, 1, 1, 1};
        tbl[3]  = '{0, 0, 0, 12, 1, 0, 0, 1};
        tbl[4]  = '{1, 2, 0,  1, 0, 1, 1, 1};
        tbl[5]  = '{0, 0, 0, 12, 1, 0, 0, 1};
        tbl[6]  = '{0, 0, 0,  0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0,  0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0,  0, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 0, 12, 1, 0, 0, 1};
        tbl[10] = '{1, 3, 0,  8, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 0,  0, 0, 0, 0, 0};
        tbl[12] = '{1, 0, 0, 12, 1, 0, 0, 1};

        repeat (3) @(negedge clk);
        #1;
        check("reset_we", int'(wr_if.pix_we), 0);
        check("reset_addr", int'(wr_if.pix_addr), 0);
        check("reset_done", int'(frame_done), 0);
        check("reset_err", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int e = 0; e < 13; e++) begin
            make_image(tbl[e].fill);
            model_frame(tbl[e]);
            ga0 = got_a.size();
            dn0 = done_n;
            er0 = err_n;
            drive_frame(tbl[e]);
            nw = got_a.size() - ga0;
            check($sformatf("f%0d_writes", e), nw, tbl[e].ew);
            check($sformatf("f%0d_model_n", e), exp_a.size(), nw);
            for (int i = 0; i < nw && i < exp_a.size(); i++) begin
                check($sformatf("f%0d_addr%0d", e, i),
                      got_a[ga0 + i], exp_a[i]);
                check($sformatf("f%0d_data%0d", e, i),
                      int'(got_d[ga0 + i]), int'(exp_d[i]));
            end
            if (tbl[e].fill == 1 && nw > 9)
                check("addr9_data", int'(got_d[ga0 + 9]), 1);
            check($sformatf("f%0d_done", e), done_n - dn0, tbl[e].ed);
            check($sformatf("f%0d_err", e), err_n - er0, tbl[e].ee);
            check($sformatf("f%0d_busy", e), int'(busy), tbl[e].eb);
            if (tbl[e].ed != 0 && done_n > dn0)
                check($sformatf("f%0d_done_after_we", e),
                      int'(done_cyc > last_we_cyc), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
